// File: rtl/cmd_reply_encoder.sv
// Serialises one captured command reply into a fixed-length Ethernet frame on
// the tx AXI-Stream, host-addressed, FPGA-sourced, with a per-frame sequence.
module cmd_reply_encoder #(
   parameter logic [47:0] HOST_MAC_ADDR = 48'h985aebdb066f,
   parameter logic [47:0] FPGA_MAC_ADDR = 48'h5a0102030405,
   parameter int unsigned FRAME_BYTES   = 60
) (
   input  logic        gtx_clk_bufg,
   input  logic        gtx_resetn,
   input  logic        rsp_valid,
   output logic        rsp_ready,
   input  logic [15:0] rsp_cmd_type,
   input  logic [15:0] rsp_cmd_op,
   input  logic [31:0] rsp_cmd_id,
   input  logic [31:0] rsp_addr,
   input  logic [31:0] rsp_data,
   output logic [7:0]  tx_axis_tdata,
   output logic        tx_axis_tvalid,
   output logic        tx_axis_tlast,
   input  logic        tx_axis_tready,
   output logic [15:0] frame_seq,
   output logic        busy
);

   localparam int unsigned CNT_W    = 8;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);
   localparam logic [15:0] BODY_LEN = 16'h0010;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_nxt_idx;
   logic [7:0]       r_tdata, w_tdata_nxt, w_nxt_byte;
   logic             r_tvalid, w_tvalid_nxt;
   logic             r_tlast, w_tlast_nxt;
   logic             r_rsp_ready, w_rsp_ready_nxt;
   logic             r_busy, w_busy_nxt;
   logic             w_capture, w_seq_inc;
   logic [15:0]      r_seq;
   logic [15:0]      r_type, r_op;
   logic [31:0]      r_id, r_addr, r_data;

   // Byte that follows the one currently on the bus
   always_comb begin
      w_nxt_idx = r_cnt + 8'd1;
      case (w_nxt_idx)
         8'd0:    w_nxt_byte = HOST_MAC_ADDR[47:40];
         8'd1:    w_nxt_byte = HOST_MAC_ADDR[39:32];
         8'd2:    w_nxt_byte = HOST_MAC_ADDR[31:24];
         8'd3:    w_nxt_byte = HOST_MAC_ADDR[23:16];
         8'd4:    w_nxt_byte = HOST_MAC_ADDR[15:8];
         8'd5:    w_nxt_byte = HOST_MAC_ADDR[7:0];
         8'd6:    w_nxt_byte = FPGA_MAC_ADDR[47:40];
         8'd7:    w_nxt_byte = FPGA_MAC_ADDR[39:32];
         8'd8:    w_nxt_byte = FPGA_MAC_ADDR[31:24];
         8'd9:    w_nxt_byte = FPGA_MAC_ADDR[23:16];
         8'd10:   w_nxt_byte = FPGA_MAC_ADDR[15:8];
         8'd11:   w_nxt_byte = FPGA_MAC_ADDR[7:0];
         8'd12:   w_nxt_byte = BODY_LEN[15:8];
         8'd13:   w_nxt_byte = BODY_LEN[7:0];
         8'd14:   w_nxt_byte = r_seq[7:0];
         8'd15:   w_nxt_byte = r_seq[15:8];
         8'd16:   w_nxt_byte = r_type[15:8];
         8'd17:   w_nxt_byte = r_type[7:0];
         8'd18:   w_nxt_byte = r_op[15:8];
         8'd19:   w_nxt_byte = r_op[7:0];
         8'd20:   w_nxt_byte = r_id[7:0];
         8'd21:   w_nxt_byte = r_id[15:8];
         8'd22:   w_nxt_byte = r_id[23:16];
         8'd23:   w_nxt_byte = r_id[31:24];
         8'd24:   w_nxt_byte = r_addr[7:0];
         8'd25:   w_nxt_byte = r_addr[15:8];
         8'd26:   w_nxt_byte = r_addr[23:16];
         8'd27:   w_nxt_byte = r_addr[31:24];
         8'd28:   w_nxt_byte = r_data[7:0];
         8'd29:   w_nxt_byte = r_data[15:8];
         8'd30:   w_nxt_byte = r_data[23:16];
         8'd31:   w_nxt_byte = r_data[31:24];
         default: w_nxt_byte = 8'h00;
      endcase
   end

   // Next-state and registered-output logic
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_tdata_nxt     = r_tdata;
      w_tvalid_nxt    = r_tvalid;
      w_tlast_nxt     = r_tlast;
      w_rsp_ready_nxt = r_rsp_ready;
      w_busy_nxt      = r_busy;
      w_capture       = 1'b0;
      w_seq_inc       = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_rsp_ready_nxt = 1'b1;
            w_busy_nxt      = 1'b0;
            w_tvalid_nxt    = 1'b0;
            w_tlast_nxt     = 1'b0;
            w_tdata_nxt     = 8'h00;
            if (rsp_valid) begin
               w_capture       = 1'b1;
               w_state_nxt     = S_SEND;
               w_cnt_nxt       = '0;
               w_tdata_nxt     = HOST_MAC_ADDR[47:40];
               w_tvalid_nxt    = 1'b1;
               w_rsp_ready_nxt = 1'b0;
               w_busy_nxt      = 1'b1;
            end
         end
         S_SEND: begin
            if (tx_axis_tready) begin
               if (r_tlast) begin
                  w_state_nxt     = S_IDLE;
                  w_cnt_nxt       = '0;
                  w_tdata_nxt     = 8'h00;
                  w_tvalid_nxt    = 1'b0;
                  w_tlast_nxt     = 1'b0;
                  w_rsp_ready_nxt = 1'b1;
                  w_busy_nxt      = 1'b0;
                  w_seq_inc       = 1'b1;
               end else begin
                  w_cnt_nxt   = w_nxt_idx;
                  w_tdata_nxt = w_nxt_byte;
                  w_tlast_nxt = (w_nxt_idx == LAST_IDX);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
      if (!gtx_resetn) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_tdata     <= 8'h00;
         r_tvalid    <= 1'b0;
         r_tlast     <= 1'b0;
         r_rsp_ready <= 1'b1;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_tdata     <= w_tdata_nxt;
         r_tvalid    <= w_tvalid_nxt;
         r_tlast     <= w_tlast_nxt;
         r_rsp_ready <= w_rsp_ready_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   // Sequence number only moves on a completed frame
   always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
      if (!gtx_resetn) begin
         r_seq <= 16'h0000;
      end else if (w_seq_inc) begin
         r_seq <= r_seq + 16'h0001;
      end
   end

   // Holding registers, frozen for the whole frame
   always_ff @(posedge gtx_clk_bufg or negedge gtx_resetn) begin
      if (!gtx_resetn) begin
         r_type <= 16'h0000;
         r_op   <= 16'h0000;
         r_id   <= 32'h0;
         r_addr <= 32'h0;
         r_data <= 32'h0;
      end else if (w_capture) begin
         r_type <= rsp_cmd_type;
         r_op   <= rsp_cmd_op;
         r_id   <= rsp_cmd_id;
         r_addr <= rsp_addr;
         r_data <= rsp_data;
      end
   end

   assign rsp_ready      = r_rsp_ready;
   assign tx_axis_tdata  = r_tdata;
   assign tx_axis_tvalid = r_tvalid;
   assign tx_axis_tlast  = r_tlast;
   assign frame_seq      = r_seq;
   assign busy           = r_busy;

endmodule

// File: tb/tb_cmd_reply_encoder.sv
// Directed bench for cmd_reply_encoder: table of reply requests with
// hand-computed frame headers, plus back-to-back, wrap and mid-frame reset.
module tb_cmd_reply_encoder;

   logic        gtx_clk_bufg = 1'b0;
   logic        gtx_resetn   = 1'b0;
   logic        rsp_valid    = 1'b0;
   logic        rsp_ready;
   logic [15:0] rsp_cmd_type = 16'h0;
   logic [15:0] rsp_cmd_op   = 16'h0;
   logic [31:0] rsp_cmd_id   = 32'h0;
   logic [31:0] rsp_addr     = 32'h0;
   logic [31:0] rsp_data     = 32'h0;
   logic [7:0]  tx_axis_tdata;
   logic        tx_axis_tvalid;
   logic        tx_axis_tlast;
   logic        tx_axis_tready = 1'b1;
   logic [15:0] frame_seq;
   logic        busy;

   cmd_reply_encoder dut (
      .gtx_clk_bufg   (gtx_clk_bufg),
      .gtx_resetn     (gtx_resetn),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_cmd_type   (rsp_cmd_type),
      .rsp_cmd_op     (rsp_cmd_op),
      .rsp_cmd_id     (rsp_cmd_id),
      .rsp_addr       (rsp_addr),
      .rsp_data       (rsp_data),
      .tx_axis_tdata  (tx_axis_tdata),
      .tx_axis_tvalid (tx_axis_tvalid),
      .tx_axis_tlast  (tx_axis_tlast),
      .tx_axis_tready (tx_axis_tready),
      .frame_seq      (frame_seq),
      .busy           (busy)
   );

   always #4 gtx_clk_bufg = ~gtx_clk_bufg;

   typedef struct {
      logic [15:0]  typ;
      logic [15:0]  op;
      logic [31:0]  id;
      logic [31:0]  addr;
      logic [31:0]  data;
      int           mode;      // 0: always ready, 1: stall at byte 5 then toggle
      logic [255:0] hdr;       // expected bytes 0..31, byte 0 in the MSBs
      logic [15:0]  seq_after;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   logic [7:0]  rx_q[$];
   int          rx_last_pos;
   int          stall_errs;
   int          ready_errs;
   logic        timed_out;
   vec_t        vecs[3];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Receive one frame starting at a negedge where tvalid is already high
   task automatic collect(input int mode);
      int         stall_cnt  = 0;
      int         cyc        = 0;
      logic       tog        = 1'b1;
      logic       done       = 1'b0;
      logic       prev_stall = 1'b0;
      logic [7:0] prev_d     = 8'h00;
      logic       prev_l     = 1'b0;
      rx_q.delete();
      rx_last_pos = -1;
      stall_errs  = 0;
      ready_errs  = 0;
      timed_out   = 1'b0;
      while (!done && cyc < 4000) begin
         if (prev_stall && (tx_axis_tvalid !== 1'b1 || tx_axis_tdata !== prev_d ||
                            tx_axis_tlast !== prev_l))
            stall_errs++;
         if (tx_axis_tvalid === 1'b1 && (rsp_ready !== 1'b0 || busy !== 1'b1))
            ready_errs++;
         if (mode == 0 || rx_q.size() < 5) begin
            tx_axis_tready = 1'b1;
         end else if (stall_cnt < 32) begin
            tx_axis_tready = 1'b0;
            stall_cnt++;
         end else begin
            tx_axis_tready = tog;
            tog = ~tog;
         end
         if (tx_axis_tvalid === 1'b1 && tx_axis_tready) begin
            rx_q.push_back(tx_axis_tdata);
            if (tx_axis_tlast === 1'b1) begin
               rx_last_pos = rx_q.size() - 1;
               done = 1'b1;
            end
         end
         prev_stall = (tx_axis_tvalid === 1'b1) && !tx_axis_tready;
         prev_d     = tx_axis_tdata;
         prev_l     = tx_axis_tlast;
         @(negedge gtx_clk_bufg);
         cyc++;
      end
      tx_axis_tready = 1'b1;
      if (!done) timed_out = 1'b1;
   endtask

   task automatic chk_frame(input string name, input logic [255:0] hdr);
      chk({name, " timeout"}, 64'(timed_out), 64'd0);
      chk({name, " len"}, 64'(rx_q.size()), 64'd60);
      chk({name, " tlast pos"}, 64'(rx_last_pos), 64'd59);
      chk({name, " stall stable"}, 64'(stall_errs), 64'd0);
      chk({name, " ready/busy in frame"}, 64'(ready_errs), 64'd0);
      for (int i = 0; i < 60; i++) begin
         logic [7:0]  e;
         logic [63:0] a;
         e = (i < 32) ? hdr[255 - 8*i -: 8] : 8'h00;
         a = (i < rx_q.size()) ? 64'(rx_q[i]) : 64'hdead;
         chk($sformatf("%s byte%0d", name, i), a, 64'(e));
      end
   endtask

   // Present a request at the current negedge and check first-byte latency
   task automatic send(input logic [15:0] t, input logic [15:0] op, input logic [31:0] id,
                       input logic [31:0] a, input logic [31:0] d, input logic hold,
                       input string name);
      rsp_cmd_type = t;
      rsp_cmd_op   = op;
      rsp_cmd_id   = id;
      rsp_addr     = a;
      rsp_data     = d;
      rsp_valid    = 1'b1;
      chk({name, " rsp_ready idle"}, 64'(rsp_ready), 64'd1);
      @(negedge gtx_clk_bufg);
      if (!hold) rsp_valid = 1'b0;
      chk({name, " N+1 tvalid"}, 64'(tx_axis_tvalid), 64'd1);
      chk({name, " N+1 tdata"}, 64'(tx_axis_tdata), 64'h98);
      chk({name, " N+1 busy"}, 64'(busy), 64'd1);
      chk({name, " N+1 rsp_ready"}, 64'(rsp_ready), 64'd0);
   endtask

   task automatic chk_end(input string name, input logic [15:0] seq);
      chk({name, " end tvalid"}, 64'(tx_axis_tvalid), 64'd0);
      chk({name, " end tlast"}, 64'(tx_axis_tlast), 64'd0);
      chk({name, " end rsp_ready"}, 64'(rsp_ready), 64'd1);
      chk({name, " end busy"}, 64'(busy), 64'd0);
      chk({name, " frame_seq"}, 64'(frame_seq), 64'(seq));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{16'h4343, 16'h5252, 32'h4, 32'hfeedbeef, 32'h12345678, 0,
                  256'h985aebdb066f_5a0102030405_0010_0000_4343_5252_04000000_efbeedfe_78563412,
                  16'h0001};
      vecs[1] = '{16'h4343, 16'h5252, 32'h4, 32'hfeedbeef, 32'h12345678, 1,
                  256'h985aebdb066f_5a0102030405_0010_0100_4343_5252_04000000_efbeedfe_78563412,
                  16'h0002};
      vecs[2] = '{16'h4343, 16'h5757, 32'ha1b2c3d4, 32'h00000000, 32'hffffffff, 1,
                  256'h985aebdb066f_5a0102030405_0010_0200_4343_5757_d4c3b2a1_00000000_ffffffff,
                  16'h0003};

      // Reset values
      @(negedge gtx_clk_bufg);
      @(negedge gtx_clk_bufg);
      chk("rst tvalid", 64'(tx_axis_tvalid), 64'd0);
      chk("rst tlast", 64'(tx_axis_tlast), 64'd0);
      chk("rst tdata", 64'(tx_axis_tdata), 64'd0);
      chk("rst rsp_ready", 64'(rsp_ready), 64'd1);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst frame_seq", 64'(frame_seq), 64'd0);
      gtx_resetn = 1'b1;
      @(negedge gtx_clk_bufg);

      // Table-driven single replies
      for (int v = 0; v < 3; v++) begin
         string nm;
         nm = $sformatf("vec%0d", v);
         send(vecs[v].typ, vecs[v].op, vecs[v].id, vecs[v].addr, vecs[v].data, 1'b0, nm);
         collect(vecs[v].mode);
         chk_frame(nm, vecs[v].hdr);
         chk_end(nm, vecs[v].seq_after);
         @(negedge gtx_clk_bufg);
      end

      // Back-to-back with held rsp_valid and fields changed mid-frame
      gtx_resetn = 1'b0;
      @(negedge gtx_clk_bufg);
      gtx_resetn = 1'b1;
      @(negedge gtx_clk_bufg);
      send(16'h4343, 16'h5252, 32'h7, 32'hfeedbeef, 32'h12345678, 1'b1, "b2b1");
      rsp_cmd_id = 32'h8;
      rsp_data   = 32'hdeadbeef;
      collect(0);
      chk_frame("b2b1", 256'h985aebdb066f_5a0102030405_0010_0000_4343_5252_07000000_efbeedfe_78563412);
      chk("b2b gap tvalid", 64'(tx_axis_tvalid), 64'd0);
      chk("b2b gap rsp_ready", 64'(rsp_ready), 64'd1);
      chk("b2b gap frame_seq", 64'(frame_seq), 64'd1);
      @(negedge gtx_clk_bufg);
      rsp_valid = 1'b0;
      chk("b2b2 start tvalid", 64'(tx_axis_tvalid), 64'd1);
      chk("b2b2 start tdata", 64'(tx_axis_tdata), 64'h98);
      collect(0);
      chk_frame("b2b2", 256'h985aebdb066f_5a0102030405_0010_0100_4343_5252_08000000_efbeedfe_efbeadde);
      chk_end("b2b2", 16'h0002);
      @(negedge gtx_clk_bufg);

      // Sequence wrap
      force dut.r_seq = 16'hffff;
      @(negedge gtx_clk_bufg);
      release dut.r_seq;
      chk("wrap preload", 64'(frame_seq), 64'hffff);
      send(16'h4343, 16'h5252, 32'h9, 32'h00000010, 32'h00000020, 1'b0, "wrap1");
      collect(0);
      chk_frame("wrap1", 256'h985aebdb066f_5a0102030405_0010_ffff_4343_5252_09000000_10000000_20000000);
      chk_end("wrap1", 16'h0000);
      @(negedge gtx_clk_bufg);
      send(16'h4343, 16'h5252, 32'ha, 32'h00000010, 32'h00000020, 1'b0, "wrap2");
      collect(0);
      chk_frame("wrap2", 256'h985aebdb066f_5a0102030405_0010_0000_4343_5252_0a000000_10000000_20000000);
      chk_end("wrap2", 16'h0001);
      @(negedge gtx_clk_bufg);

      // Reset while byte 20 is on the bus
      send(16'h4343, 16'h5252, 32'h20, 32'hfeedbeef, 32'h12345678, 1'b0, "rstmid");
      repeat (20) @(negedge gtx_clk_bufg);
      chk("rstmid byte20", 64'(tx_axis_tdata), 64'h20);
      #1 gtx_resetn = 1'b0;
      #1;
      chk("rstmid async tvalid", 64'(tx_axis_tvalid), 64'd0);
      chk("rstmid async tlast", 64'(tx_axis_tlast), 64'd0);
      chk("rstmid async tdata", 64'(tx_axis_tdata), 64'd0);
      chk("rstmid async busy", 64'(busy), 64'd0);
      chk("rstmid async rsp_ready", 64'(rsp_ready), 64'd1);
      chk("rstmid async frame_seq", 64'(frame_seq), 64'd0);
      @(negedge gtx_clk_bufg);
      gtx_resetn = 1'b1;
      @(negedge gtx_clk_bufg);
      send(16'h4343, 16'h5252, 32'h21, 32'hfeedbeef, 32'h12345678, 1'b0, "postrst");
      collect(0);
      chk_frame("postrst", 256'h985aebdb066f_5a0102030405_0010_0000_4343_5252_21000000_efbeedfe_78563412);
      chk_end("postrst", 16'h0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
